// File: rtl/spi_flash_be_slave.sv
// SPI mode-0 responder emulating the bulk-erase subset of an M25P16-class flash.
// Define SPI_FLASH_RDID_EN to answer RDID (8'h9F) with the three ID bytes.
module spi_flash_be_slave #(
  parameter int unsigned BE_CYCLES = 1000,
  parameter logic [7:0]  ID_BYTE0  = 8'h20,
  parameter logic [7:0]  ID_BYTE1  = 8'h20,
  parameter logic [7:0]  ID_BYTE2  = 8'h15
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic cs_n,
  input  logic sck,
  input  logic mosi,
  output logic miso,
  output logic wel,
  output logic wip,
  output logic be_done,
  output logic cmd_err
);
`ifdef SPI_FLASH_RDID_EN
  localparam bit RDID_EN = 1'b1;
`else
  localparam bit RDID_EN = 1'b0;
`endif
  localparam int CW = $clog2(BE_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARMED, S_RESP, S_IGNORE} state_t;

  state_t        state_q;
  logic [2:0]    cs_q, sck_q;
  logic [1:0]    mosi_q;
  logic [2:0]    bit_q, bidx_q;
  logic [1:0]    byte_q;
  logic          is_id_q;
  logic [7:0]    sh_q, tx_q;
  logic          miso_q, wel_q, wip_q, be_done_q, cmd_err_q;
  logic [CW-1:0] cnt_q;

  logic       cs_fall, cs_rise, sck_rise, sck_fall;
  logic [7:0] cmd_d, first_byte, byte_d;

  // [1] is the synchronised level, [2] the previous one for edge detection
  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign cs_rise  = ~cs_q[2] & cs_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  assign sck_fall = sck_q[2] & ~sck_q[1];
  assign cmd_d    = {sh_q[6:0], mosi_q[1]};

  // Status is re-sampled at the start of every byte so RDSR polling sees wip fall
  always_comb begin
    first_byte = {6'b0, wel_q, wip_q};
    if (is_id_q) begin
      case (byte_q)
        2'd0:    first_byte = ID_BYTE0;
        2'd1:    first_byte = ID_BYTE1;
        2'd2:    first_byte = ID_BYTE2;
        default: first_byte = 8'h00;
      endcase
    end
  end
  assign byte_d = (bidx_q == 3'd0) ? first_byte : tx_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      cs_q      <= 3'b111;
      sck_q     <= 3'b000;
      mosi_q    <= 2'b00;
      bit_q     <= 3'd0;
      bidx_q    <= 3'd0;
      byte_q    <= 2'd0;
      is_id_q   <= 1'b0;
      sh_q      <= 8'h00;
      tx_q      <= 8'h00;
      miso_q    <= 1'b0;
      wel_q     <= 1'b0;
      wip_q     <= 1'b0;
      be_done_q <= 1'b0;
      cmd_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cs_q      <= {cs_q[1:0], cs_n};
      sck_q     <= {sck_q[1:0], sck};
      mosi_q    <= {mosi_q[0], mosi};
      be_done_q <= 1'b0;
      cmd_err_q <= 1'b0;

      if (wip_q) begin
        if (cnt_q == '0) begin
          wip_q     <= 1'b0;
          be_done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end

      case (state_q)
        S_IDLE: if (cs_fall) begin
          state_q <= S_CMD;
          bit_q   <= 3'd0;
        end
        S_CMD: begin
          if (cs_rise) begin
            state_q   <= S_IDLE;
            cmd_err_q <= 1'b1;
          end else if (sck_rise) begin
            sh_q  <= cmd_d;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              bidx_q  <= 3'd0;
              byte_q  <= 2'd0;
              is_id_q <= 1'b0;
              case (cmd_d)
                8'h05: state_q <= S_RESP;
                8'h9F: begin
                  state_q <= RDID_EN ? S_RESP : S_IGNORE;
                  is_id_q <= RDID_EN;
                end
                // writes are silently dropped while an erase is running
                8'h06, 8'h04, 8'hC7: state_q <= wip_q ? S_IGNORE : S_ARMED;
                default: state_q <= S_IGNORE;
              endcase
            end
          end
        end
        S_ARMED: begin
          if (cs_rise) begin
            state_q <= S_IDLE;
            case (sh_q)
              8'h06: wel_q <= 1'b1;
              8'h04: wel_q <= 1'b0;
              8'hC7: if (wel_q && !wip_q) begin
                wel_q <= 1'b0;
                wip_q <= 1'b1;
                cnt_q <= CW'(BE_CYCLES - 1);
              end
              default: ;
            endcase
          end else if (sck_rise) begin
            state_q   <= S_IGNORE;
            cmd_err_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (cs_rise) begin
            state_q <= S_IDLE;
            miso_q  <= 1'b0;
          end else if (sck_fall) begin
            miso_q <= byte_d[7];
            tx_q   <= {byte_d[6:0], 1'b0};
            bidx_q <= bidx_q + 3'd1;
            if (bidx_q == 3'd7 && byte_q != 2'd3) byte_q <= byte_q + 2'd1;
          end
        end
        S_IGNORE: if (cs_rise) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign miso    = miso_q & ~cs_q[1];
  assign wel     = wel_q;
  assign wip     = wip_q;
  assign be_done = be_done_q;
  assign cmd_err = cmd_err_q;
endmodule

// File: tb/tb_spi_flash_be_slave.sv
// Bench for spi_flash_be_slave: timeline model of status/erase plus directed and random SPI frames.
module tb_spi_flash_be_slave;
  localparam int BEC = 1000;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0, cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic miso, wel, wip, be_done, cmd_err;

  spi_flash_be_slave #(.BE_CYCLES(BEC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .wel(wel), .wip(wip), .be_done(be_done), .cmd_err(cmd_err)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {int t; int nbits; logic [7:0] op; int dec_t;} ev_t;
  ev_t evq[$];

  int   cyc = 0, n_chk = 0, n_fail = 0;
  int   e_start = 0, e_end = 0, last_cs_chg = 0, done_cnt = 0, err_cnt = 0;
  logic m_wel = 1'b0;

  // Model: pin change at the negedge of cycle k takes effect at posedge k+3;
  // an erase accepted at edge E keeps wip high for edges E..E+BEC-1.
  function automatic logic wip_at(int t);
    return (t >= e_start) && (t < e_end);
  endfunction

  function automatic logic armable(logic [7:0] op);
    return op == 8'h06 || op == 8'h04 || op == 8'hC7;
  endfunction

  function automatic logic [7:0] exp_resp(logic [7:0] op, int k, int f0);
    if (op == 8'h05) return {6'b0, m_wel, wip_at(f0 + 2)};
`ifdef SPI_FLASH_RDID_EN
    if (op == 8'h9F) return (k == 0) ? 8'h20 : (k == 1) ? 8'h20 : (k == 2) ? 8'h15 : 8'h00;
`endif
    return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare process
  initial begin
    logic rst_e, exp_err, busy;
    ev_t ev;
    forever begin
      @(posedge sys_clk);
      cyc++;
      rst_e = !sys_rst_n;
      @(negedge sys_clk);
      exp_err = 1'b0;
      if (rst_e) begin
        m_wel = 1'b0; e_start = 0; e_end = 0; evq.delete();
      end else begin
        while (evq.size() > 0 && evq[0].t <= cyc) begin
          ev = evq.pop_front();
          busy = wip_at(ev.dec_t - 1);
          if (ev.nbits < 8) exp_err = 1'b1;
          else if (ev.nbits > 8) exp_err = armable(ev.op) && !busy;
          else if (armable(ev.op) && !busy) begin
            if (ev.op == 8'h06) m_wel = 1'b1;
            else if (ev.op == 8'h04) m_wel = 1'b0;
            else if (m_wel && !wip_at(cyc - 1)) begin
              m_wel = 1'b0; e_start = cyc; e_end = cyc + BEC;
            end
          end
        end
      end
      chk("wel", wel, m_wel);
      chk("wip", wip, wip_at(cyc));
      chk("be_done", be_done, cyc == e_end);
      chk("cmd_err", cmd_err, exp_err);
      if (cs_n && cyc >= last_cs_chg + 2) chk("miso_idle", miso, 1'b0);
      if (be_done) done_cnt++;
      if (cmd_err) err_cnt++;
    end
  end

  task automatic tick;
    @(negedge sys_clk);
  endtask

  task automatic spi_clk(input logic b, output logic r, output int fc, output int rc);
    sck = 1'b0; mosi = b; fc = cyc;
    tick; tick;
    sck = 1'b1; rc = cyc;
    tick;
    r = miso;
    tick;
  endtask

  task automatic frame(input logic [7:0] op, input int nbits, input int nresp, output logic [31:0] rb);
    logic r;
    logic [7:0] b;
    int fc, rc, f0, dec_t;
    ev_t ev;
    rb = '0; b = '0; f0 = 0; dec_t = 0;
    cs_n = 1'b0; last_cs_chg = cyc;
    tick; tick;
    for (int i = 0; i < nbits; i++) begin
      spi_clk((i < 8) ? op[7-i] : 1'($urandom % 2), r, fc, rc);
      if (i == 7) dec_t = rc + 3;
      if (i == 8) begin
        ev = '{t: rc + 3, nbits: nbits, op: op, dec_t: dec_t};
        evq.push_back(ev);
      end
    end
    if (nbits == 8) begin
      for (int k = 0; k < nresp; k++) begin
        for (int j = 0; j < 8; j++) begin
          spi_clk(1'($urandom % 2), r, fc, rc);
          if (j == 0) f0 = fc;
          b = {b[6:0], r};
        end
        chk("resp_byte", b, exp_resp(op, k, f0));
        rb = {rb[23:0], b};
      end
    end
    sck = 1'b0;
    tick; tick;
    cs_n = 1'b1; last_cs_chg = cyc;
    if (nbits <= 8) begin
      ev = '{t: cyc + 3, nbits: nbits, op: op, dec_t: dec_t};
      evq.push_back(ev);
    end
    repeat (6) tick;
  endtask

  initial begin
    logic [31:0] rb;
    logic [7:0]  op;
    int t, d0, e0, nb, nr, w;
    repeat (4) tick;
    sys_rst_n = 1'b1;
    tick;
    chk("rst_miso", miso, 1'b0);
    chk("rst_wel", wel, 1'b0);
    chk("rst_wip", wip, 1'b0);
    chk("rst_be_done", be_done, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);

    // BE without write enable
    d0 = done_cnt;
    frame(8'hC7, 8, 0, rb);
    repeat (10) tick;
    chk("be_nowel_wip", wip, 1'b0);
    chk("be_nowel_wel", wel, 1'b0);

    // WREN then BE, exact erase length
    frame(8'h06, 8, 0, rb);
    chk("wren_wel", wel, 1'b1);
    frame(8'hC7, 8, 0, rb);
    t = last_cs_chg;
    chk("be_wel", wel, 1'b0);
    chk("be_wip", wip, 1'b1);
    for (w = 0; w < 1100 && wip; w++) tick;
    chk("be_len", cyc - t, 1003);
    tick;
    chk("be_done_once", done_cnt - d0, 1);

    // RDSR polling across erase completion
    frame(8'h06, 8, 0, rb);
    frame(8'hC7, 8, 0, rb);
    e0 = last_cs_chg + 3;
    while (cyc < e0 + 950) tick;
    frame(8'h05, 8, 2, rb);
    chk("rdsr_poll", rb[15:0], 16'h0100);

    // Over-length WREN, then truncated WRDI
    d0 = err_cnt;
    frame(8'h06, 9, 0, rb);
    chk("overlen_wel", wel, 1'b0);
    chk("overlen_err", err_cnt - d0, 1);
    frame(8'h06, 8, 0, rb);
    d0 = err_cnt;
    frame(8'h04, 5, 0, rb);
    chk("trunc_wel", wel, 1'b1);
    chk("trunc_err", err_cnt - d0, 1);

    // Reset mid-erase
    frame(8'hC7, 8, 0, rb);
    d0 = done_cnt;
    repeat (500) tick;
    sys_rst_n = 1'b0;
    tick;
    sys_rst_n = 1'b1;
    tick;
    chk("rstmid_wip", wip, 1'b0);
    chk("rstmid_wel", wel, 1'b0);
    chk("rstmid_miso", miso, 1'b0);
    repeat (700) tick;
    chk("rstmid_no_done", done_cnt - d0, 0);
    frame(8'h05, 8, 1, rb);
    chk("rstmid_rdsr", rb[7:0], 8'h00);

    // RDID
    frame(8'h9F, 8, 4, rb);
`ifdef SPI_FLASH_RDID_EN
    chk("rdid", rb, 32'h2020_1500);
`else
    chk("rdid", rb, 32'h0000_0000);
`endif

    // Random frames against the model
    for (int i = 0; i < 80; i++) begin
      case ($urandom % 8)
        0: op = 8'h05;
        1, 6: op = 8'h06;
        2: op = 8'h04;
        3, 7: op = 8'hC7;
        4: op = 8'h9F;
        default: op = 8'($urandom);
      endcase
      if ($urandom % 5 != 0) nb = 8;
      else case ($urandom % 6)
        0: nb = 0; 1: nb = 3; 2: nb = 5; 3: nb = 7; 4: nb = 9; default: nb = 10;
      endcase
      nr = (nb == 8 && (op == 8'h05 || op == 8'h9F)) ? int'($urandom % 3) : 0;
      frame(op, nb, nr, rb);
      repeat ($urandom % 40) tick;
      if ($urandom % 6 == 0) repeat (1010) tick;
    end

    repeat (10) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_flash_be_slave.md
Name: spi_flash_be_slave

Overview:
- SPI mode-0 responder that emulates the bulk-erase subset of an M25P16-class serial flash, for on-FPGA loopback against the team's flash erase controller and for RTL-only simulation without the vendor model.
- Oversamples cs_n/sck/mosi in the sys_clk domain, decodes instruction bytes, keeps the WEL/WIP status bits, runs a timed erase, and returns status/ID on miso.

Parameters:
- BE_CYCLES, 1000, sys_clk cycles that WIP stays high after an accepted bulk erase (must be ≥1).
- ID_BYTE0, 8'h20, RDID manufacturer byte.
- ID_BYTE1, 8'h20, RDID memory-type byte.
- ID_BYTE2, 8'h15, RDID capacity byte.

Ports:
- sys_clk  input  1  system clock, 50 MHz; sck must be ≤ sys_clk/4.
- sys_rst_n  input  1  reset. Synchronous and active-low, sampled on the sys_clk rising edge.
- cs_n  input  1  SPI chip select, active-low, asynchronous to sys_clk.
- sck  input  1  SPI clock, idle low (mode 0).
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first.
- wel  output  1  write-enable latch.
- wip  output  1  write-in-progress (erase busy).
- be_done  output  1  one-cycle pulse when an erase completes.
- cmd_err  output  1  one-cycle pulse when a select is discarded (see Behaviour).

Behaviour:
Reset (sys_rst_n low at a clock edge):
- miso = 0, wel = 0, wip = 0, be_done = 0, cmd_err = 0.
- Synchronisers are loaded with idle values cs_n = 1, sck = 0.
- FSM returns to IDLE and the erase counter is cleared.
- Reset mid-erase aborts the erase; be_done does not fire.

Input synchronisation and edge detection:
- cs_n, sck and mosi each pass through a 2-flop synchroniser, then a 1-flop edge detector.
- Each event is detected 3 sys_clk cycles after the pin change.

FSM states:
- IDLE: leave on a cs_n falling edge, clear the bit counter, go to CMD.
- CMD: on each sck rising edge, shift in mosi; after 8 bits, decode the opcode:
  - 8'h05 RDSR → RESP, response byte = {6'b0, wel, wip}, re-sampled at the start of every byte (so polling observes wip fall).
  - 8'h9F RDID → RESP with the ID sequence (optional feature only).
  - 8'h06 WREN, 8'h04 WRDI, 8'hC7 BE → ARMED.
  - Any other opcode → IGNORE.
  - A cs_n rising edge in CMD before 8 bits → IDLE plus a cmd_err pulse.
- ARMED: on a cs_n rising edge with no further sck rising edge, execute the command, then go to IDLE.
  - WREN: wel = 1.
  - WRDI: wel = 0.
  - BE: if wel = 1 and wip = 0, then wel = 0, wip = 1 and the counter loads BE_CYCLES-1; otherwise no effect.
  - Any sck rising edge in ARMED (more than 8 bits) → IGNORE and cmd_err pulse; the command is not executed.
- RESP:
  - On each sck falling edge, drive the next bit on miso.
  - The MSB of the first response byte is driven on the falling edge that follows the 8th command bit.
  - Bytes repeat or advance continuously while cs_n stays low.
  - A cs_n rising edge → IDLE, miso = 0.
- IGNORE: wait for the cs_n rising edge → IDLE.

Busy handling:
- While wip = 1, only RDSR (and RDID) is decoded.
- WREN, WRDI and BE go to IGNORE with no cmd_err pulse.

Erase counter:
- Decrements every cycle while wip = 1.
- At 0: wip = 0 and be_done = 1 for exactly one cycle in the same cycle.
- If a cs_n edge and erase completion fall in the same cycle, both are processed.

Outputs:
- miso is forced to 0 whenever the synchronised cs_n is high.
- wel, wip, be_done and cmd_err are registered.

Optional Feature:
- Macro: SPI_FLASH_RDID_EN.
- Defined: opcode 8'h9F enters RESP and returns ID_BYTE0, ID_BYTE1, ID_BYTE2, then repeats 8'h00 until cs_n rises.
- Undefined: 8'h9F is treated as an unknown opcode (IGNORE, miso stays 0), and the ID parameters are unused.

Test Plan:
- Erase with write enable: WREN (8'h06) frame, then BE (8'hC7) frame at sck = 12.5 MHz, BE_CYCLES = 1000.
  - Required: wel = 1 after the WREN frame.
  - Required: wel = 0, wip = 1 about 3 cycles after the BE cs_n rise.
  - Required: wip falls and be_done pulses once, exactly 1000 cycles later.
- Erase without write enable: BE frame only → wel = 0, wip stays 0, no be_done.
- RDSR polling during erase: RDSR frame holding cs_n low for 16 further sck cycles.
  - Required: miso reads 8'h01 while busy.
  - Required: the next byte reads 8'h00 once the erase has completed.
- Over-length and truncated frames:
  - WREN followed by a 9th sck clock before cs_n rise → wel stays 0, cmd_err pulses once.
  - A 5-bit frame → cmd_err pulses, no state change.
- Reset mid-erase: assert sys_rst_n low 500 cycles into an erase → wip = 0, wel = 0, miso = 0, no be_done; a following RDSR returns 8'h00.
- With SPI_FLASH_RDID_EN: RDID frame with 32 response clocks → miso returns 8'h20, 8'h20, 8'h15, 8'h00. Without the macro the same frame returns all zeros.
